// File: rtl/sysreg_spr_bank_if.sv
// Request/response bundle for the banked stack-pointer register file.
// The requester side (execute stage) drives the *_REQ strobes and data.
// The register bank returns the selected value, save-stack status and fault state.
interface sysreg_spr_bank_if #(
  parameter int N     = 32,
  parameter int BANKS = 2,
  parameter int DEPTH = 4,
  localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
);
  logic [BW-1:0] iBANK_SEL;
  logic          iREGIST_REQ;
  logic [N-1:0]  iREGIST_DATA;
  logic          iADJ_REQ;
  logic          iADJ_DIR;
  logic          iLIMIT_REQ;
  logic [N-1:0]  iLIMIT_DATA;
  logic          iSAVE_REQ;
  logic          iRESTORE_REQ;
  logic          iFAULT_CLEAR;
  logic [N-1:0]  oINFO_DATA;
  logic [CW-1:0] oSTACK_COUNT;
  logic          oSAVE_FULL;
  logic          oSAVE_EMPTY;
  logic          oFAULT;
  logic [1:0]    oFAULT_CODE;

  modport master (
    output iBANK_SEL, iREGIST_REQ, iREGIST_DATA, iADJ_REQ, iADJ_DIR,
           iLIMIT_REQ, iLIMIT_DATA, iSAVE_REQ, iRESTORE_REQ, iFAULT_CLEAR,
    input  oINFO_DATA, oSTACK_COUNT, oSAVE_FULL, oSAVE_EMPTY, oFAULT, oFAULT_CODE
  );

  modport slave (
    input  iBANK_SEL, iREGIST_REQ, iREGIST_DATA, iADJ_REQ, iADJ_DIR,
           iLIMIT_REQ, iLIMIT_DATA, iSAVE_REQ, iRESTORE_REQ, iFAULT_CLEAR,
    output oINFO_DATA, oSTACK_COUNT, oSAVE_FULL, oSAVE_EMPTY, oFAULT, oFAULT_CODE
  );
endinterface

// File: rtl/sysreg_spr_bank.sv
// Banked stack-pointer registers, one per privilege mode, each with a lower
// stack limit, plus a LIFO save stack used on nested exception entry/return.
// All requests address the bank chosen by iBANK_SEL; faults latch stickily.
module sysreg_spr_bank #(
  parameter int N      = 32,
  parameter int BANKS  = 2,
  parameter int DEPTH  = 4,
  parameter int STRIDE = 4,
  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic            iCLOCK,
  input logic            iRESET_SYNC,
  sysreg_spr_bank_if.slave bus
);

  localparam logic [N-1:0] STRIDE_N = N'(STRIDE);
  localparam logic [N:0]   STRIDE_X = (N + 1)'(STRIDE);

  logic [N-1:0]  bank_q  [BANKS];
  logic [N-1:0]  limit_q [BANKS];
  logic [N-1:0]  stack_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic [BW-1:0] sel;
  logic [N-1:0]  cur, lim, top, bank_d;
  logic [N:0]    dec_full;
  logic [SW-1:0] top_idx, push_idx;
  logic          empty, full, swap, push, pop;
  logic          overflow, underflow, lim_fault;
  logic [1:0]    new_code;

  // Out-of-range bank selects fold onto bank 0 so every request has a target.
  always_comb begin
    sel = (int'(bus.iBANK_SEL) < BANKS) ? bus.iBANK_SEL : '0;
  end

  // Next bank value, save-stack movement and fault causes for this cycle.
  always_comb begin
    cur      = bank_q[sel];
    lim      = limit_q[sel];
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    top_idx  = SW'(count_q - 1'b1);
    push_idx = SW'(count_q);
    top      = stack_q[top_idx];

    // Save and restore together on a non-empty stack exchange bank and top.
    swap      = bus.iSAVE_REQ & bus.iRESTORE_REQ & ~empty;
    pop       = bus.iRESTORE_REQ & ~empty & ~bus.iSAVE_REQ;
    push      = bus.iSAVE_REQ & ~swap & ~full;
    overflow  = bus.iSAVE_REQ & ~swap & full;
    underflow = bus.iRESTORE_REQ & empty;

    // The borrow bit catches wrap below zero even when the limit is 0.
    dec_full  = {1'b0, cur} - STRIDE_X;
    lim_fault = 1'b0;
    bank_d    = cur;
    if (bus.iREGIST_REQ) begin
      bank_d = bus.iREGIST_DATA;
    end else if (swap || pop) begin
      bank_d = top;
    end else if (bus.iADJ_REQ) begin
      if (bus.iADJ_DIR) begin
        bank_d = cur + STRIDE_N;
      end else if (!dec_full[N] && (dec_full[N-1:0] >= lim)) begin
        bank_d = dec_full[N-1:0];
      end else begin
        lim_fault = 1'b1;
      end
    end

    count_d = count_q;
    if (push) count_d = count_q + 1'b1;
    else if (pop) count_d = count_q - 1'b1;

    new_code = underflow ? 2'd3 : overflow ? 2'd2 : lim_fault ? 2'd1 : 2'd0;

    // A clear opens the latch; a fault arriving in the same cycle still lands.
    fault_d = fault_q;
    code_d  = code_q;
    if (bus.iFAULT_CLEAR) begin
      fault_d = 1'b0;
      code_d  = 2'd0;
    end
    if ((new_code != 2'd0) && (!fault_q || bus.iFAULT_CLEAR)) begin
      fault_d = 1'b1;
      code_d  = new_code;
    end
  end

  // Per-bank value and limit registers; only the selected bank ever moves.
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
        bank_q[gi]  <= '0;
        limit_q[gi] <= '0;
      end else if (sel == BW'(gi)) begin
        bank_q[gi] <= bank_d;
        if (bus.iLIMIT_REQ) limit_q[gi] <= bus.iLIMIT_DATA;
      end
    end
  end

  // Save-stack storage always captures the pre-update bank value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
    always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
        stack_q[gi] <= '0;
      end else if ((swap && (top_idx == SW'(gi))) || (push && (push_idx == SW'(gi)))) begin
        stack_q[gi] <= cur;
      end
    end
  end

  // Occupancy and sticky fault latch.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      count_q <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign bus.oINFO_DATA   = cur;
  assign bus.oSTACK_COUNT = count_q;
  assign bus.oSAVE_FULL   = full;
  assign bus.oSAVE_EMPTY  = empty;
  assign bus.oFAULT       = fault_q;
  assign bus.oFAULT_CODE  = code_q;

endmodule

// File: tb/tb_sysreg_spr_bank.sv
// Directed vector table for the documented scenarios, then randomized traffic
// checked against a queue-based reference model of the register bank.
module tb_sysreg_spr_bank;

  localparam int N     = 32;
  localparam int BANKS = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sysreg_spr_bank_if #(.N(N), .BANKS(BANKS), .DEPTH(DEPTH)) bus ();

  sysreg_spr_bank #(.N(N), .BANKS(BANKS), .DEPTH(DEPTH), .STRIDE(4)) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .bus         (bus)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        rst;
    logic        rg;
    logic [31:0] rdata;
    logic        adj;
    logic        dir;
    logic        lq;
    logic [31:0] ldata;
    logic        sv;
    logic        rs;
    logic        clr;
    logic [31:0] e_info;
    int          e_cnt;
    logic        e_f;
    logic [1:0]  e_code;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] mb[BANKS];
  logic [31:0] ml[BANKS];
  logic [31:0] mstk[$];
  logic        mf;
  logic [1:0]  mcode;

  function automatic vec_t mk(input logic [1:0] sel, input logic r, input logic rg,
                              input logic [31:0] rdata, input logic adj, input logic dir,
                              input logic lq, input logic [31:0] ldata, input logic sv,
                              input logic rs, input logic clr, input logic [31:0] e_info,
                              input int e_cnt, input logic e_f, input logic [1:0] e_code);
    vec_t v;
    v.sel = sel; v.rst = r; v.rg = rg; v.rdata = rdata; v.adj = adj; v.dir = dir;
    v.lq = lq; v.ldata = ldata; v.sv = sv; v.rs = rs; v.clr = clr;
    v.e_info = e_info; v.e_cnt = e_cnt; v.e_f = e_f; v.e_code = e_code;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                = v.rst;
    bus.iBANK_SEL      = v.sel;
    bus.iREGIST_REQ    = v.rg;
    bus.iREGIST_DATA   = v.rdata;
    bus.iADJ_REQ       = v.adj;
    bus.iADJ_DIR       = v.dir;
    bus.iLIMIT_REQ     = v.lq;
    bus.iLIMIT_DATA    = v.ldata;
    bus.iSAVE_REQ      = v.sv;
    bus.iRESTORE_REQ   = v.rs;
    bus.iFAULT_CLEAR   = v.clr;
  endtask

  // One clock of the reference model, written straight from the register rules.
  task automatic model_step(input vec_t v);
    int b;
    logic [31:0] old, nb, rval;
    logic rok, uf, ovf, lf;
    logic [1:0] code;
    if (v.rst) begin
      for (int i = 0; i < BANKS; i++) begin mb[i] = 0; ml[i] = 0; end
      mstk.delete();
      mf = 0; mcode = 0;
      return;
    end
    b = (int'(v.sel) < BANKS) ? int'(v.sel) : 0;
    old = mb[b]; nb = old; rval = 0;
    rok = 0; uf = 0; ovf = 0; lf = 0;
    if (v.sv && v.rs && mstk.size() > 0) begin
      rval = mstk[$];
      mstk[$] = old;
      rok = 1;
    end else begin
      if (v.rs) begin
        if (mstk.size() > 0) begin rval = mstk.pop_back(); rok = 1; end
        else uf = 1;
      end
      if (v.sv) begin
        if (mstk.size() == DEPTH) ovf = 1;
        else mstk.push_back(old);
      end
    end
    if (v.rg) nb = v.rdata;
    else if (rok) nb = rval;
    else if (v.adj) begin
      if (v.dir) nb = old + 32'd4;
      else if (old < 32'd4 || (old - 32'd4) < ml[b]) lf = 1;
      else nb = old - 32'd4;
    end
    mb[b] = nb;
    if (v.lq) ml[b] = v.ldata;
    code = uf ? 2'd3 : ovf ? 2'd2 : lf ? 2'd1 : 2'd0;
    if (v.clr) begin mf = 0; mcode = 0; end
    if (code != 0 && !mf) begin mf = 1; mcode = code; end
  endtask

  initial begin
    vec_t v;
    int sb;
    // sel rst rg rdata adj dir lq ldata sv rs clr | info cnt f code
    tv.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 32'h0,0,0,0));
    tv.push_back(mk(0,0,1,32'h1000,0,0,0,0,0,0,0, 32'h1000,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h0FF8,0,0,0, 32'h1000,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,0,0,0,0, 32'h0FFC,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,0,0,0,0, 32'h0FF8,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,0,0,0,0, 32'h0FF8,0,1,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,1, 32'h0FF8,0,0,0));
    tv.push_back(mk(1,0,1,32'hAAAA0000,0,0,0,0,0,0,0, 32'hAAAA0000,0,0,0));
    tv.push_back(mk(0,0,1,32'h1234,0,0,0,0,0,0,0, 32'h1234,0,0,0));
    tv.push_back(mk(1,0,0,0,1,0,0,0,0,0,0, 32'hAAA9FFFC,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 32'h1234,0,0,0));
    tv.push_back(mk(0,0,1,32'h10,0,0,0,0,0,0,0, 32'h10,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 32'h10,1,0,0));
    tv.push_back(mk(0,0,1,32'h20,0,0,0,0,0,0,0, 32'h20,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 32'h20,2,0,0));
    tv.push_back(mk(0,0,1,32'h30,0,0,0,0,0,0,0, 32'h30,2,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 32'h30,3,0,0));
    tv.push_back(mk(0,0,1,32'h40,0,0,0,0,0,0,0, 32'h40,3,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 32'h40,4,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 32'h40,4,1,2));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,1, 32'h40,4,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 32'h40,3,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 32'h30,2,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 32'h20,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 32'h10,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 32'h10,0,1,3));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,1, 32'h10,0,0,0));
    tv.push_back(mk(0,0,1,32'h300,0,0,0,0,0,0,0, 32'h300,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 32'h300,1,0,0));
    tv.push_back(mk(0,0,1,32'h500,0,0,0,0,0,0,0, 32'h500,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,1,0, 32'h300,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 32'h500,0,0,0));
    tv.push_back(mk(0,0,1,32'hFFFFFFFC,0,0,0,0,0,0,0, 32'hFFFFFFFC,0,0,0));
    tv.push_back(mk(0,0,0,0,1,1,0,0,0,0,0, 32'h0,0,0,0));
    tv.push_back(mk(0,0,1,32'h77,1,1,0,0,0,0,0, 32'h77,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 32'h77,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 32'h77,2,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,0,0,0,0, 32'h77,2,1,1));
    tv.push_back(mk(0,1,0,0,0,0,0,0,1,0,0, 32'h0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 32'h0,0,0,0));
    tv.push_back(mk(3,0,1,32'hBEEF,0,0,0,0,0,0,0, 32'hBEEF,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 32'hBEEF,0,0,0));

    drive(tv[0]);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      @(posedge clk);
      #1;
      $display("vec %0d: sel=%0d info=0x%08h cnt=%0d fault=%0b code=%0d", i, tv[i].sel,
               bus.oINFO_DATA, bus.oSTACK_COUNT, bus.oFAULT, bus.oFAULT_CODE);
      chk($sformatf("vec%0d info", i), bus.oINFO_DATA, tv[i].e_info);
      chk($sformatf("vec%0d count", i), 32'(bus.oSTACK_COUNT), 32'(tv[i].e_cnt));
      chk($sformatf("vec%0d fault", i), 32'(bus.oFAULT), 32'(tv[i].e_f));
      chk($sformatf("vec%0d code", i), 32'(bus.oFAULT_CODE), 32'(tv[i].e_code));
      chk($sformatf("vec%0d full", i), 32'(bus.oSAVE_FULL), 32'(tv[i].e_cnt == DEPTH));
      chk($sformatf("vec%0d empty", i), 32'(bus.oSAVE_EMPTY), 32'(tv[i].e_cnt == 0));
    end

    // Randomized traffic against the reference model, starting from reset.
    v = mk(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 500; i++) begin
      if (i > 0) begin
        v.rst   = ($urandom_range(0, 63) == 0);
        v.sel   = 2'($urandom_range(0, 3));
        v.rg    = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 2))
          0: v.rdata = $urandom_range(0, 64);
          1: v.rdata = 32'hFFFFFFF0 + $urandom_range(0, 15);
          default: v.rdata = $urandom;
        endcase
        v.adj   = $urandom_range(0, 1);
        v.dir   = $urandom_range(0, 1);
        v.lq    = ($urandom_range(0, 7) == 0);
        v.ldata = $urandom_range(0, 48);
        v.sv    = ($urandom_range(0, 3) == 0);
        v.rs    = ($urandom_range(0, 3) == 0);
        v.clr   = ($urandom_range(0, 7) == 0);
      end
      drive(v);
      model_step(v);
      @(posedge clk);
      #1;
      sb = (int'(v.sel) < BANKS) ? int'(v.sel) : 0;
      $display("rnd %0d: sel=%0d info=0x%08h cnt=%0d fault=%0b code=%0d", i, v.sel,
               bus.oINFO_DATA, bus.oSTACK_COUNT, bus.oFAULT, bus.oFAULT_CODE);
      chk($sformatf("rnd%0d info", i), bus.oINFO_DATA, mb[sb]);
      chk($sformatf("rnd%0d count", i), 32'(bus.oSTACK_COUNT), 32'(mstk.size()));
      chk($sformatf("rnd%0d fault", i), 32'(bus.oFAULT), 32'(mf));
      chk($sformatf("rnd%0d code", i), 32'(bus.oFAULT_CODE), 32'(mcode));
      chk($sformatf("rnd%0d full", i), 32'(bus.oSAVE_FULL), 32'(mstk.size() == DEPTH));
      chk($sformatf("rnd%0d empty", i), 32'(bus.oSAVE_EMPTY), 32'(mstk.size() == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
